// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle between the arbitrating master and a single APB slave.
interface apb_master_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PWRITE;
  logic              PSEL;
  logic              PENABLE;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master: IDLE -> SETUP -> ACCESS per transfer,
// PREADY wait states, timeout abort, one-cycle response strobe per request.
module apb_master_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic                rsp_valid,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  apb_master_arbiter_if.master apb
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              id_q, id_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              gnt;

  // Next-state, grant and response logic; PSEL/PENABLE are registered from the next state.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = '0;
    gnt         = (req_valid == 2'b11) ? prio_q : req_valid[1];

    unique case (state_q)
      S_IDLE: begin
        if (!PRESET && req_valid[gnt]) begin
          req_ready[gnt] = 1'b1;
          paddr_d  = gnt ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
          pwdata_d = gnt ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          pwrite_d = req_write[gnt];
          id_d     = gnt;
          prio_d   = ~gnt;
          state_d  = S_SETUP;
          psel_d   = 1'b1;
        end
      end
      S_SETUP: begin
        cnt_d     = '0;
        state_d   = S_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        if (apb.PREADY) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : apb.PRDATA;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          psel_d    = 1'b1;
          penable_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= S_IDLE;
      prio_q      <= 1'b0;
      cnt_q       <= '0;
      id_q        <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: vector table of single transfers
// plus hand-written reset, contention and reset-mid-ACCESS sequences.
module tb_apb_master_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          PCLK;
  logic          PRESET;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_id;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  apb_master_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

  apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb       (apb)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  write;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    int          waits;      // ACCESS cycles with PREADY=0 before PREADY=1
    logic [31:0] prdata;
    logic [1:0]  exp_ready;
    logic        exp_id;
    logic        exp_write;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_acc;    // number of ACCESS cycles
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int idx, input vec_t v);
    int   acc;
    logic stable;
    logic seen_rsp;
    acc = 0;
    stable = 1'b1;
    seen_rsp = 1'b0;
    // accept cycle
    @(negedge PCLK);
    req_valid = v.valid;
    req_write = v.write;
    req_addr  = {v.addr1, v.addr0};
    req_wdata = {v.wdata1, v.wdata0};
    apb.PREADY = 1'b0;
    apb.PRDATA = 32'h1111_1111;
    #1 chk($sformatf("v%0d_ready", idx), 64'(req_ready), 64'(v.exp_ready));
    // SETUP cycle
    @(negedge PCLK);
    req_valid = 2'b00;
    #1;
    chk($sformatf("v%0d_setup_psel", idx), 64'({apb.PSEL, apb.PENABLE}), 64'(2'b10));
    chk($sformatf("v%0d_paddr", idx), 64'(apb.PADDR), 64'(v.exp_addr));
    chk($sformatf("v%0d_pwrite", idx), 64'(apb.PWRITE), 64'(v.exp_write));
    chk($sformatf("v%0d_pwdata", idx), 64'(apb.PWDATA), 64'(v.exp_wdata));
    // ACCESS cycles until the response cycle, bounded
    for (int k = 0; k < int'(TO) + 4; k++) begin
      @(negedge PCLK);
      apb.PREADY = (acc == v.waits);
      apb.PRDATA = (acc == v.waits) ? v.prdata : 32'h1111_1111;
      #1;
      if (apb.PSEL && apb.PENABLE) begin
        acc++;
        if (apb.PADDR !== v.exp_addr || apb.PWRITE !== v.exp_write) stable = 1'b0;
      end else begin
        seen_rsp = 1'b1;
        break;
      end
    end
    apb.PREADY = 1'b0;
    chk($sformatf("v%0d_rsp_seen", idx), 64'(seen_rsp), 64'(1'b1));
    chk($sformatf("v%0d_access_cycles", idx), 64'(acc), 64'(v.exp_acc));
    chk($sformatf("v%0d_addr_stable", idx), 64'(stable), 64'(1'b1));
    chk($sformatf("v%0d_psel_idle", idx), 64'(apb.PSEL), 64'(1'b0));
    chk($sformatf("v%0d_rsp_valid", idx), 64'(rsp_valid), 64'(1'b1));
    chk($sformatf("v%0d_rsp_id", idx), 64'(rsp_id), 64'(v.exp_id));
    chk($sformatf("v%0d_rsp_err", idx), 64'(rsp_err), 64'(v.exp_err));
    chk($sformatf("v%0d_rsp_rdata", idx), 64'(rsp_rdata), 64'(v.exp_rdata));
    chk($sformatf("v%0d_paddr_hold", idx), 64'(apb.PADDR), 64'(v.exp_addr));
    @(negedge PCLK);
    #1 chk($sformatf("v%0d_rsp_one_cycle", idx), 64'(rsp_valid), 64'(1'b0));
  endtask

  initial begin
    //            valid  write  addr0  addr1  wdata0        wdata1        waits prdata        rdy    id   wr   addr   wdata         err  rdata         acc
    vecs[0] = '{2'b01, 2'b01, 32'h10, 32'h0,  32'hA5A5_0001, 32'h0,        0,  32'h0,        2'b01, 1'b0, 1'b1, 32'h10, 32'hA5A5_0001, 1'b0, 32'h0,        1};
    vecs[1] = '{2'b10, 2'b00, 32'h0,  32'h20, 32'h0,        32'h2222,     3,  32'hDEAD_BEEF, 2'b10, 1'b1, 1'b0, 32'h20, 32'h2222,     1'b0, 32'hDEAD_BEEF, 4};
    vecs[2] = '{2'b11, 2'b10, 32'h30, 32'h34, 32'h3030,     32'h3434,     1,  32'h1234_5678, 2'b01, 1'b0, 1'b0, 32'h30, 32'h3030,     1'b0, 32'h1234_5678, 2};
    vecs[3] = '{2'b11, 2'b10, 32'h40, 32'h44, 32'h4040,     32'h0BAD_F00D, 0, 32'hFFFF_FFFF, 2'b10, 1'b1, 1'b1, 32'h44, 32'h0BAD_F00D, 1'b0, 32'h0,        1};
    vecs[4] = '{2'b01, 2'b00, 32'h50, 32'h0,  32'h5050,     32'h0,        99, 32'h5555_5555, 2'b01, 1'b0, 1'b0, 32'h50, 32'h5050,     1'b1, 32'h0,        16};
    vecs[5] = '{2'b10, 2'b00, 32'h0,  32'h60, 32'h0,        32'h6060,     15, 32'hCAFE_0001, 2'b10, 1'b1, 1'b0, 32'h60, 32'h6060,     1'b0, 32'hCAFE_0001, 16};
    vecs[6] = '{2'b01, 2'b01, 32'h70, 32'h0,  32'h7070,     32'h0,        14, 32'h0,        2'b01, 1'b0, 1'b1, 32'h70, 32'h7070,     1'b0, 32'h0,        15};

    PRESET     = 1'b1;
    req_valid  = 2'b00;
    req_write  = 2'b00;
    req_addr   = '0;
    req_wdata  = '0;
    apb.PREADY = 1'b0;
    apb.PRDATA = '0;

    // Reset state; req_ready must stay low while reset is asserted
    repeat (2) @(negedge PCLK);
    req_valid = 2'b11;
    #1;
    chk("rst_ready", 64'(req_ready), 64'(2'b00));
    chk("rst_psel", 64'({apb.PSEL, apb.PENABLE, apb.PWRITE}), 64'(3'b000));
    chk("rst_paddr", 64'(apb.PADDR), 64'(0));
    chk("rst_pwdata", 64'(apb.PWDATA), 64'(0));
    chk("rst_rsp", 64'({rsp_valid, rsp_id, rsp_err}), 64'(3'b000));
    chk("rst_rdata", 64'(rsp_rdata), 64'(0));

    // Contention from reset: both valid, zero-wait slave; grants 0,1,0,1 every 3 cycles
    for (int c = 0; c < 12; c++) begin
      @(negedge PCLK);
      if (c == 0) begin
        PRESET     = 1'b0;
        req_valid  = 2'b11;
        req_write  = 2'b11;
        req_addr   = {32'h200, 32'h100};
        req_wdata  = {32'hBBBB_0002, 32'hAAAA_0001};
        apb.PREADY = 1'b1;
        apb.PRDATA = 32'h7777_7777;
      end
      #1;
      chk($sformatf("cont_ready_c%0d", c), 64'(req_ready),
          64'((c % 3 == 0) ? (((c / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00));
      if (c % 3 == 1)
        chk($sformatf("cont_paddr_c%0d", c), 64'(apb.PADDR),
            64'((((c / 3) % 2) == 0) ? 32'h100 : 32'h200));
      if (c % 3 == 0 && c > 0) begin
        chk($sformatf("cont_rsp_valid_c%0d", c), 64'(rsp_valid), 64'(1'b1));
        chk($sformatf("cont_rsp_id_c%0d", c), 64'(rsp_id), 64'((((c / 3) - 1) % 2)));
      end
    end
    @(negedge PCLK);
    req_valid  = 2'b00;
    apb.PREADY = 1'b0;
    #1;
    chk("cont_last_rsp_valid", 64'(rsp_valid), 64'(1'b1));
    chk("cont_last_rsp_id", 64'(rsp_id), 64'(1'b1));
    chk("cont_last_rdata", 64'(rsp_rdata), 64'(0));

    // Vector table: single transfers with various wait patterns and timeout
    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset during a wait-state ACCESS
    @(negedge PCLK);
    req_valid  = 2'b10;
    req_write  = 2'b00;
    req_addr   = {32'h80, 32'h90};
    req_wdata  = {32'h8080, 32'h9090};
    apb.PREADY = 1'b0;
    #1 chk("mr_ready", 64'(req_ready), 64'(2'b10));
    @(negedge PCLK);
    req_valid = 2'b00;
    #1 chk("mr_setup", 64'({apb.PSEL, apb.PENABLE}), 64'(2'b10));
    @(negedge PCLK);
    #1 chk("mr_access", 64'({apb.PSEL, apb.PENABLE}), 64'(2'b11));
    @(negedge PCLK);
    PRESET    = 1'b1;
    req_valid = 2'b11;
    @(negedge PCLK);
    #1;
    chk("mr_psel", 64'({apb.PSEL, apb.PENABLE, apb.PWRITE}), 64'(3'b000));
    chk("mr_paddr", 64'(apb.PADDR), 64'(0));
    chk("mr_pwdata", 64'(apb.PWDATA), 64'(0));
    chk("mr_rsp", 64'({rsp_valid, rsp_err}), 64'(2'b00));
    chk("mr_ready_in_rst", 64'(req_ready), 64'(2'b00));
    PRESET = 1'b0;
    #1 chk("mr_prio_reset", 64'(req_ready), 64'(2'b01));
    @(negedge PCLK);
    req_valid  = 2'b00;
    apb.PREADY = 1'b1;
    apb.PRDATA = 32'h9999_0000;
    #1;
    chk("mr_no_stale_rsp", 64'(rsp_valid), 64'(1'b0));
    chk("mr_paddr_new", 64'(apb.PADDR), 64'(32'h90));
    @(negedge PCLK);
    #1 chk("mr_no_stale_rsp2", 64'(rsp_valid), 64'(1'b0));
    @(negedge PCLK);
    apb.PREADY = 1'b0;
    #1;
    chk("mr_rsp_valid", 64'(rsp_valid), 64'(1'b1));
    chk("mr_rsp_id", 64'(rsp_id), 64'(1'b0));
    chk("mr_rsp_rdata", 64'(rsp_rdata), 64'(32'h9999_0000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
